// File: rtl/sprite_pkg.sv
// Shared types and default geometry for the animated sprite renderer.
package sprite_pkg;

  typedef enum logic {IDLE, PLAY} anim_state_t;

  typedef logic [3:0] color_idx_t;

  localparam int SPR_W_DEF       = 92;
  localparam int SPR_H_DEF       = 90;
  localparam int NUM_FRAMES_DEF  = 4;
  localparam int ADDR_W_DEF      = 16;
  localparam int SCALE_LOG2_DEF  = 1;
  localparam int FRAME_TICKS_DEF = 6;
  localparam int TRANSP_IDX_DEF  = 0;

  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage

// File: rtl/sprite_anim_renderer_if.sv
// Pixel-side and ROM-side signal bundle between the VGA pipeline and the sprite renderer.
interface sprite_anim_renderer_if
  import sprite_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int FRAME_W = 2
) ();

  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              blank;
  logic              frame_start;
  logic [9:0]        pos_x;
  logic [9:0]        pos_y;
  logic              flip_x;
  logic              anim_start;
  logic              anim_loop;
  logic [ADDR_W-1:0] rom_address;
  color_idx_t        rom_q;
  color_idx_t        pix_index;
  logic              pix_opaque;
  logic              anim_busy;
  logic [FRAME_W-1:0] cur_frame;

  modport master (
    output DrawX, DrawY, blank, frame_start, pos_x, pos_y, flip_x,
           anim_start, anim_loop, rom_q,
    input  rom_address, pix_index, pix_opaque, anim_busy, cur_frame
  );

  modport slave (
    input  DrawX, DrawY, blank, frame_start, pos_x, pos_y, flip_x,
           anim_start, anim_loop, rom_q,
    output rom_address, pix_index, pix_opaque, anim_busy, cur_frame
  );

endinterface

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: counts video frames per animation frame and steps the displayed frame.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int FW          = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          i_frame_start,
  input  logic          i_anim_start,
  input  logic          i_anim_loop,
  output logic          o_anim_busy,
  output logic [FW-1:0] o_cur_frame
);

  localparam int TW = $clog2(FRAME_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(FRAME_TICKS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(NUM_FRAMES - 1);

  anim_state_t   r_state, w_next_state;
  logic [TW-1:0] r_tick, w_next_tick;
  logic [FW-1:0] r_frame, w_next_frame;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_tick  <= '0;
      r_frame <= '0;
    end else begin
      r_state <= w_next_state;
      r_tick  <= w_next_tick;
      r_frame <= w_next_frame;
    end
  end

  // A restart outranks a coincident frame_start, so that tick is never counted.
  always_comb begin
    w_next_state = r_state;
    w_next_tick  = r_tick;
    w_next_frame = r_frame;
    case (r_state)
      IDLE: begin
        w_next_tick  = '0;
        w_next_frame = '0;
        if (i_anim_start) w_next_state = PLAY;
      end
      PLAY: begin
        if (i_anim_start) begin
          w_next_tick  = '0;
          w_next_frame = '0;
        end else if (i_frame_start) begin
          if (r_tick == TICK_LAST) begin
            w_next_tick = '0;
            if (r_frame == FRAME_LAST) begin
              w_next_frame = '0;
              if (!i_anim_loop) w_next_state = IDLE;
            end else begin
              w_next_frame = r_frame + FW'(1);
            end
          end else begin
            w_next_tick = r_tick + TW'(1);
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign o_anim_busy = (r_state == PLAY);
  assign o_cur_frame = r_frame;

endmodule

// File: rtl/sprite_anim_renderer.sv
// Positioned, scaled, mirrorable animated sprite: ROM address generation and registered pixel output.
module sprite_anim_renderer
  import sprite_pkg::*;
#(
  parameter int SPR_W       = SPR_W_DEF,
  parameter int SPR_H       = SPR_H_DEF,
  parameter int NUM_FRAMES  = NUM_FRAMES_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SCALE_LOG2  = SCALE_LOG2_DEF,
  parameter int FRAME_TICKS = FRAME_TICKS_DEF,
  parameter int TRANSP_IDX  = TRANSP_IDX_DEF
) (
  input  logic vga_clk,
  input  logic reset,
  sprite_anim_renderer_if.slave bus
);

  localparam int FW        = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int FRAME_PIX = frame_pixels(SPR_W, SPR_H);
  localparam logic [9:0] HIT_W = 10'(SPR_W << SCALE_LOG2);
  localparam logic [9:0] HIT_H = 10'(SPR_H << SCALE_LOG2);

  logic [9:0]        r_px, r_py;
  logic              r_flip;
  color_idx_t        r_pix_index;
  logic              r_pix_opaque;
  logic signed [10:0] w_rx, w_ry;
  logic              w_hit;
  logic [9:0]        w_sx_raw, w_sx, w_sy;
  logic [ADDR_W-1:0] w_addr;
  logic [FW-1:0]     w_cur_frame;
  logic              w_anim_busy;

  sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_TICKS(FRAME_TICKS),
    .FW         (FW)
  ) u_ctrl (
    .vga_clk      (vga_clk),
    .reset        (reset),
    .i_frame_start(bus.frame_start),
    .i_anim_start (bus.anim_start),
    .i_anim_loop  (bus.anim_loop),
    .o_anim_busy  (w_anim_busy),
    .o_cur_frame  (w_cur_frame)
  );

  // Position and mirror are only sampled in vertical blanking to avoid tearing.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_px   <= '0;
      r_py   <= '0;
      r_flip <= 1'b0;
    end else if (bus.frame_start) begin
      r_px   <= bus.pos_x;
      r_py   <= bus.pos_y;
      r_flip <= bus.flip_x;
    end
  end

  assign w_rx     = $signed({1'b0, bus.DrawX}) - $signed({1'b0, r_px});
  assign w_ry     = $signed({1'b0, bus.DrawY}) - $signed({1'b0, r_py});
  assign w_hit    = !w_rx[10] && (w_rx[9:0] < HIT_W) && !w_ry[10] && (w_ry[9:0] < HIT_H);
  assign w_sx_raw = w_rx[9:0] >> SCALE_LOG2;
  assign w_sx     = r_flip ? (10'(SPR_W - 1) - w_sx_raw) : w_sx_raw;
  assign w_sy     = w_ry[9:0] >> SCALE_LOG2;
  assign w_addr   = ADDR_W'(w_cur_frame) * ADDR_W'(FRAME_PIX)
                  + ADDR_W'(w_sy) * ADDR_W'(SPR_W) + ADDR_W'(w_sx);

  assign bus.rom_address = w_hit ? w_addr : '0;

  // The ROM answers on the falling edge, so rom_q pairs with this cycle's hit/blank.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_pix_index  <= '0;
      r_pix_opaque <= 1'b0;
    end else begin
      r_pix_index  <= (w_hit && bus.blank) ? bus.rom_q : '0;
      r_pix_opaque <= w_hit && bus.blank && (bus.rom_q != color_idx_t'(TRANSP_IDX));
    end
  end

  assign bus.pix_index  = r_pix_index;
  assign bus.pix_opaque = r_pix_opaque;
  assign bus.anim_busy  = w_anim_busy;
  assign bus.cur_frame  = w_cur_frame;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed self-checking bench for sprite_anim_renderer; the ROM returns address[3:0] ^ 4'hA.
module tb_sprite_anim_renderer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checkCount = 0;
  int   errorCount = 0;

  sprite_anim_renderer_if #(.ADDR_W(16), .FRAME_W(2)) bus ();

  sprite_anim_renderer dut (
    .vga_clk(clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) bus.rom_q = bus.rom_address[3:0] ^ 4'hA;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input logic vis);
    bus.DrawX = x;
    bus.DrawY = y;
    bus.blank = vis;
    #1;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseFrameStart();
    bus.frame_start = 1'b1;
    stepCycle();
    bus.frame_start = 1'b0;
  endtask

  task automatic pulseAnimStart();
    bus.anim_start = 1'b1;
    stepCycle();
    bus.anim_start = 1'b0;
  endtask

  initial begin
    bus.DrawX = '0; bus.DrawY = '0; bus.blank = 1'b0; bus.frame_start = 1'b0;
    bus.pos_x = '0; bus.pos_y = '0; bus.flip_x = 1'b0;
    bus.anim_start = 1'b0; bus.anim_loop = 1'b0; bus.rom_q = '0;
    repeat (3) stepCycle();
    checkOutput("reset_opaque", 32'(bus.pix_opaque), 0);
    checkOutput("reset_index", 32'(bus.pix_index), 0);
    checkOutput("reset_busy", 32'(bus.anim_busy), 0);
    checkOutput("reset_frame", 32'(bus.cur_frame), 0);
    checkOutput("reset_addr", 32'(bus.rom_address), 0);
    reset = 1'b0;

    bus.pos_x = 10'd100; bus.pos_y = 10'd50;
    pulseFrameStart();

    applyStimulus(10'd99, 10'd50, 1'b1);
    checkOutput("left_edge_addr", 32'(bus.rom_address), 0);
    stepCycle();
    checkOutput("left_edge_opaque", 32'(bus.pix_opaque), 0);

    applyStimulus(10'd100, 10'd50, 1'b1);
    checkOutput("origin_addr", 32'(bus.rom_address), 0);
    checkOutput("origin_index_not_yet", 32'(bus.pix_index), 0);
    stepCycle();
    checkOutput("origin_index", 32'(bus.pix_index), 10);
    checkOutput("origin_opaque", 32'(bus.pix_opaque), 1);

    applyStimulus(10'd283, 10'd50, 1'b1);
    checkOutput("right_col_addr", 32'(bus.rom_address), 91);
    stepCycle();
    checkOutput("right_col_index", 32'(bus.pix_index), 1);

    applyStimulus(10'd284, 10'd50, 1'b1);
    checkOutput("past_right_addr", 32'(bus.rom_address), 0);
    stepCycle();
    checkOutput("past_right_opaque", 32'(bus.pix_opaque), 0);

    applyStimulus(10'd100, 10'd229, 1'b1);
    checkOutput("bottom_row_addr", 32'(bus.rom_address), 8188);
    stepCycle();
    checkOutput("bottom_row_index", 32'(bus.pix_index), 6);
    applyStimulus(10'd100, 10'd230, 1'b1);
    stepCycle();
    checkOutput("past_bottom_opaque", 32'(bus.pix_opaque), 0);

    bus.flip_x = 1'b1;
    pulseFrameStart();
    applyStimulus(10'd283, 10'd50, 1'b1);
    checkOutput("flip_right_addr", 32'(bus.rom_address), 0);
    applyStimulus(10'd100, 10'd50, 1'b1);
    checkOutput("flip_left_addr", 32'(bus.rom_address), 91);
    bus.flip_x = 1'b0;
    pulseFrameStart();

    bus.pos_x = 10'd200;
    applyStimulus(10'd100, 10'd50, 1'b1);
    stepCycle();
    checkOutput("midframe_old_window", 32'(bus.pix_opaque), 1);
    pulseFrameStart();
    applyStimulus(10'd100, 10'd50, 1'b1);
    stepCycle();
    checkOutput("newframe_old_pos", 32'(bus.pix_opaque), 0);
    applyStimulus(10'd200, 10'd50, 1'b1);
    stepCycle();
    checkOutput("newframe_new_pos", 32'(bus.pix_opaque), 1);
    bus.pos_x = 10'd100;
    pulseFrameStart();

    applyStimulus(10'd120, 10'd50, 1'b1);
    checkOutput("transp_addr", 32'(bus.rom_address), 10);
    stepCycle();
    checkOutput("transp_opaque", 32'(bus.pix_opaque), 0);

    applyStimulus(10'd100, 10'd50, 1'b0);
    stepCycle();
    checkOutput("blank_opaque", 32'(bus.pix_opaque), 0);
    checkOutput("blank_index", 32'(bus.pix_index), 0);

    bus.anim_loop = 1'b0;
    pulseAnimStart();
    checkOutput("start_busy", 32'(bus.anim_busy), 1);
    checkOutput("start_frame", 32'(bus.cur_frame), 0);
    for (int n = 1; n <= 24; n++) begin
      pulseFrameStart();
      checkOutput($sformatf("once_frame_%0d", n), 32'(bus.cur_frame), (n < 24) ? n / 6 : 0);
      checkOutput($sformatf("once_busy_%0d", n), 32'(bus.anim_busy), (n < 24) ? 1 : 0);
      if (n == 12) begin
        applyStimulus(10'd100, 10'd50, 1'b1);
        checkOutput("frame2_origin_addr", 32'(bus.rom_address), 16560);
      end
    end

    bus.anim_loop = 1'b1;
    pulseAnimStart();
    for (int n = 1; n <= 24; n++) begin
      pulseFrameStart();
      checkOutput($sformatf("loop_frame_%0d", n), 32'(bus.cur_frame), (n / 6) % 4);
      checkOutput($sformatf("loop_busy_%0d", n), 32'(bus.anim_busy), 1);
    end

    repeat (8) pulseFrameStart();
    checkOutput("before_restart_frame", 32'(bus.cur_frame), 1);
    bus.pos_x = 10'd300;
    bus.anim_start = 1'b1;
    bus.frame_start = 1'b1;
    stepCycle();
    bus.anim_start = 1'b0;
    bus.frame_start = 1'b0;
    checkOutput("restart_frame", 32'(bus.cur_frame), 0);
    checkOutput("restart_busy", 32'(bus.anim_busy), 1);
    applyStimulus(10'd300, 10'd50, 1'b1);
    stepCycle();
    checkOutput("restart_shadow_load", 32'(bus.pix_opaque), 1);
    bus.pos_x = 10'd100;
    repeat (5) pulseFrameStart();
    checkOutput("restart_tick_5", 32'(bus.cur_frame), 0);
    pulseFrameStart();
    checkOutput("restart_tick_6", 32'(bus.cur_frame), 1);

    repeat (6) pulseFrameStart();
    checkOutput("prereset_frame", 32'(bus.cur_frame), 2);
    applyStimulus(10'd100, 10'd50, 1'b1);
    stepCycle();
    checkOutput("prereset_opaque", 32'(bus.pix_opaque), 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_frame", 32'(bus.cur_frame), 0);
    checkOutput("async_reset_busy", 32'(bus.anim_busy), 0);
    checkOutput("async_reset_opaque", 32'(bus.pix_opaque), 0);
    stepCycle();
    reset = 1'b0;
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
